// File: rtl/zbus_pkg.sv
// Shared zbus arbitration types and helpers: FSM encoding, pointer width, one-hot decode.
package zbus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Widest port count the one-hot decoder handles.
    localparam int MAX_BN = 32;

    function automatic int ptr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int onehot_idx(input logic [MAX_BN-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_BN; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/zbus_rr_pick.sv
// Round-robin picker: first requester at or after pointer, one-hot result.
// Latency: combinational. Backpressure: none, pure function of request and pointer.
// Rotation uses a doubled request vector so the wrap needs no modulo on the vector.
module zbus_rr_pick
    import zbus_pkg::*;
#(
    parameter int BN = 2,
    parameter int PW = ptr_w(BN)
) (
    input  logic [BN-1:0] request,
    input  logic [PW-1:0] pointer,
    output logic [BN-1:0] pick,
    output logic          any
);

    logic [2*BN-1:0] dbl;
    logic [BN-1:0]   rot;
    int              sel;
    int              idx;

    always_comb begin
        pick = '0;
        dbl  = {request, request};
        rot  = dbl[pointer +: BN];
        sel  = 0;
        for (int j = BN - 1; j >= 0; j--) begin
            if (rot[j]) sel = j;
        end
        idx = int'(pointer) + sel;
        if (idx >= BN) idx = idx - BN;
        for (int i = 0; i < BN; i++) begin
            pick[i] = (rot != '0) && (idx == i);
        end
    end

    assign any = |request;

endmodule

// File: rtl/zbus_arbiter.sv
// N-to-1 zbus merge with round-robin arbitration; grant held per transfer or locked burst.
// Latency: 1 cycle arbitration from IDLE, back-to-back re-grant on release. Backpressure: zo_ack stalls owner only.
module zbus_arbiter
    import zbus_pkg::*;
#(
    parameter int   BW = 8,
    parameter int   BN = 2,
    parameter logic DI = 1'bx
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BN-1:0]    zi_vld,
    input  logic [BW*BN-1:0] zi_bus,
    input  logic [BN-1:0]    zi_lck,
    output logic [BN-1:0]    zi_ack,
    output logic             zo_vld,
    output logic [BW-1:0]    zo_bus,
    input  logic             zo_ack,
    output logic [BN-1:0]    grant,
    output logic             busy
);

    localparam int PW = ptr_w(BN);

    state_t        state, state_nxt;
    logic [BN-1:0] grant_nxt;
    logic [PW-1:0] ptr, ptr_nxt;
    logic [PW-1:0] g_idx, g_inc, pick_ptr;
    logic [BN-1:0] pick;
    logic          any;
    logic          own_vld, own_lck, xfer, rel;

    assign g_idx    = PW'(onehot_idx(MAX_BN'(grant)));
    assign g_inc    = (g_idx == PW'(BN - 1)) ? '0 : g_idx + PW'(1);
    // On release the owner drops to lowest priority by arbitrating from g+1.
    assign pick_ptr = (state == BUSY) ? g_inc : ptr;

    zbus_rr_pick #(
        .BN (BN),
        .PW (PW)
    ) u_pick (
        .request (zi_vld),
        .pointer (pick_ptr),
        .pick    (pick),
        .any     (any)
    );

    assign own_vld = |(zi_vld & grant);
    assign own_lck = |(zi_lck & grant);
    assign xfer    = own_vld & zo_ack;
    assign rel     = !own_lck && (xfer || !own_vld);

    assign zo_vld  = own_vld;
    assign zi_ack  = grant & {BN{zo_ack}};
    assign busy    = (state == BUSY);

    always_comb begin
        zo_bus = {BW{DI}};
        for (int i = 0; i < BN; i++) begin
            if (grant[i]) zo_bus = zi_bus[i*BW +: BW];
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (any) begin
                    grant_nxt = pick;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (rel) begin
                    ptr_nxt = g_inc;
                    if (any) begin
                        grant_nxt = pick;
                    end else begin
                        grant_nxt = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            ptr   <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_zbus_arbiter.sv
// Directed bench: BN=2 vector table plus hand sequences for async reset and BN=4/BN=3 rotation.
module tb_zbus_arbiter;

    logic        clk;
    logic        rst;

    logic [1:0]  vld2, lck2, zack2;
    logic [15:0] bus2;
    logic        ack2, zvld2, busy2;
    logic [7:0]  zbus2;
    logic [1:0]  grant2;

    logic [3:0]  vld4, lck4, zack4, grant4;
    logic [31:0] bus4;
    logic        ack4, zvld4, busy4;
    logic [7:0]  zbus4;

    logic [2:0]  vld3, lck3, zack3, grant3;
    logic [23:0] bus3;
    logic        ack3, zvld3, busy3;
    logic [7:0]  zbus3;

    int n_vec;
    int n_bad;

    zbus_arbiter #(.BW(8), .BN(2), .DI(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .zi_vld(vld2), .zi_bus(bus2), .zi_lck(lck2),
        .zi_ack(zack2), .zo_vld(zvld2), .zo_bus(zbus2), .zo_ack(ack2),
        .grant(grant2), .busy(busy2)
    );

    zbus_arbiter #(.BW(8), .BN(4), .DI(1'b1)) u_dut4 (
        .clk(clk), .rst(rst), .zi_vld(vld4), .zi_bus(bus4), .zi_lck(lck4),
        .zi_ack(zack4), .zo_vld(zvld4), .zo_bus(zbus4), .zo_ack(ack4),
        .grant(grant4), .busy(busy4)
    );

    zbus_arbiter #(.BW(8), .BN(3), .DI(1'b1)) u_dut3 (
        .clk(clk), .rst(rst), .zi_vld(vld3), .zi_bus(bus3), .zi_lck(lck3),
        .zi_ack(zack3), .zo_vld(zvld3), .zo_bus(zbus3), .zo_ack(ack3),
        .grant(grant3), .busy(busy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] vld;
        logic [1:0] lck;
        logic       ack;
        logic [1:0] e_grant;
        logic       e_vld;
        logic [7:0] e_bus;
        logic [1:0] e_ack;
        logic       e_busy;
    } vec_t;

    vec_t tbl[29];

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b0;
        vld2 = '0; lck2 = '0; ack2 = 1'b0; bus2 = 16'hA53C;
        vld4 = '0; lck4 = '0; ack4 = 1'b0; bus4 = 32'h4332_2110;
        vld3 = '0; lck3 = '0; ack3 = 1'b0; bus3 = 24'h32_2110;

        //         rst   vld    lck    ack   grant  vld   bus    ack    busy
        tbl[0]  = '{1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 8'hFF, 2'b00, 1'b0};
        tbl[1]  = '{1'b1, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 8'hFF, 2'b00, 1'b0};
        tbl[2]  = '{1'b1, 2'b11, 2'b00, 1'b1, 2'b01, 1'b1, 8'h3C, 2'b01, 1'b1};
        tbl[3]  = '{1'b1, 2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 8'hA5, 2'b10, 1'b1};
        tbl[4]  = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 8'hA5, 2'b00, 1'b1};
        tbl[5]  = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 8'hFF, 2'b00, 1'b0};
        // single request from port 1: one cycle of arbitration latency
        tbl[6]  = '{1'b1, 2'b10, 2'b00, 1'b1, 2'b00, 1'b0, 8'hFF, 2'b00, 1'b0};
        tbl[7]  = '{1'b1, 2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 8'hA5, 2'b10, 1'b1};
        tbl[8]  = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 8'hA5, 2'b00, 1'b1};
        tbl[9]  = '{1'b1, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 8'hFF, 2'b00, 1'b0};
        // backpressure on port 1 while port 0 waits
        tbl[10] = '{1'b1, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 8'hFF, 2'b00, 1'b0};
        for (int i = 11; i <= 15; i++)
            tbl[i] = '{1'b1, 2'b11, 2'b00, 1'b0, 2'b10, 1'b1, 8'hA5, 2'b00, 1'b1};
        tbl[16] = '{1'b1, 2'b11, 2'b00, 1'b1, 2'b10, 1'b1, 8'hA5, 2'b10, 1'b1};
        tbl[17] = '{1'b1, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, 8'h3C, 2'b01, 1'b1};
        tbl[18] = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 8'h3C, 2'b00, 1'b1};
        tbl[19] = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 8'hFF, 2'b00, 1'b0};
        // locked burst on port 0 with a two-cycle gap, port 1 waiting
        tbl[20] = '{1'b1, 2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 8'hFF, 2'b00, 1'b0};
        tbl[21] = '{1'b1, 2'b11, 2'b01, 1'b1, 2'b01, 1'b1, 8'h3C, 2'b01, 1'b1};
        tbl[22] = '{1'b1, 2'b10, 2'b11, 1'b0, 2'b01, 1'b0, 8'h3C, 2'b00, 1'b1};
        tbl[23] = '{1'b1, 2'b10, 2'b01, 1'b0, 2'b01, 1'b0, 8'h3C, 2'b00, 1'b1};
        tbl[24] = '{1'b1, 2'b11, 2'b01, 1'b1, 2'b01, 1'b1, 8'h3C, 2'b01, 1'b1};
        tbl[25] = '{1'b1, 2'b11, 2'b10, 1'b1, 2'b01, 1'b1, 8'h3C, 2'b01, 1'b1};
        tbl[26] = '{1'b1, 2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 8'hA5, 2'b10, 1'b1};
        tbl[27] = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 8'hA5, 2'b00, 1'b1};
        tbl[28] = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 8'hFF, 2'b00, 1'b0};

        for (int i = 0; i < 29; i++) begin
            @(posedge clk);
            #1;
            rst  = tbl[i].rst;
            vld2 = tbl[i].vld;
            lck2 = tbl[i].lck;
            ack2 = tbl[i].ack;
            #3;
            chk($sformatf("r%0d grant", i),  32'(grant2), 32'(tbl[i].e_grant));
            chk($sformatf("r%0d zo_vld", i), 32'(zvld2),  32'(tbl[i].e_vld));
            chk($sformatf("r%0d zo_bus", i), 32'(zbus2),  32'(tbl[i].e_bus));
            chk($sformatf("r%0d zi_ack", i), 32'(zack2),  32'(tbl[i].e_ack));
            chk($sformatf("r%0d busy", i),   32'(busy2),  32'(tbl[i].e_busy));
        end

        // async reset while port 0 owns a locked burst
        @(posedge clk);
        #1;
        vld2 = 2'b01; lck2 = 2'b01; ack2 = 1'b1;
        @(posedge clk);
        #1;
        chk("arst pre grant", 32'(grant2), 32'h1);
        chk("arst pre ack",   32'(zack2),  32'h1);
        chk("arst pre busy",  32'(busy2),  32'h1);
        #1;
        rst = 1'b0;
        #1;
        chk("arst grant",  32'(grant2), 32'h0);
        chk("arst zo_vld", 32'(zvld2),  32'h0);
        chk("arst zi_ack", 32'(zack2),  32'h0);
        chk("arst busy",   32'(busy2),  32'h0);
        chk("arst zo_bus", 32'(zbus2),  32'hFF);
        @(posedge clk);
        #1;
        rst = 1'b1;
        vld2 = '0; lck2 = '0; ack2 = 1'b0;

        // continuous requests on all ports: rotation with no idle cycles, BN=4 and BN=3
        @(posedge clk);
        #1;
        vld4 = 4'b1111; ack4 = 1'b1;
        vld3 = 3'b111;  ack3 = 1'b1;
        #3;
        chk("rr4 latency grant", 32'(grant4), 32'h0);
        chk("rr4 latency zo_vld", 32'(zvld4), 32'h0);
        chk("rr3 latency grant", 32'(grant3), 32'h0);
        for (int k = 0; k < 6; k++) begin
            logic [3:0] e4;
            logic [2:0] e3;
            logic [7:0] eb4, eb3;
            e4  = 4'b0001 << (k % 4);
            e3  = 3'b001 << (k % 3);
            eb4 = 8'h10 + 8'h11 * 8'(k % 4);
            eb3 = 8'h10 + 8'h11 * 8'(k % 3);
            @(posedge clk);
            #3;
            chk($sformatf("rr4 k%0d grant", k),  32'(grant4), 32'(e4));
            chk($sformatf("rr4 k%0d zo_vld", k), 32'(zvld4),  32'h1);
            chk($sformatf("rr4 k%0d zo_bus", k), 32'(zbus4),  32'(eb4));
            chk($sformatf("rr4 k%0d zi_ack", k), 32'(zack4),  32'(e4));
            chk($sformatf("rr3 k%0d grant", k),  32'(grant3), 32'(e3));
            chk($sformatf("rr3 k%0d zo_bus", k), 32'(zbus3),  32'(eb3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
